// File: rtl/matrix_scan_bcm_if.sv
// Panel-side bundle of matrix_scan_bcm: the scanner (master) drives addressing,
// strobes and display enable; the consumer side (slave) supplies global brightness.
interface matrix_scan_bcm_if #(
  parameter int COL_ADDR_WIDTH = 6,
  parameter int ROW_ADDR_WIDTH = 4,
  parameter int PLANES         = 6
);
  logic [7:0]                brightness;
  logic [COL_ADDR_WIDTH-1:0] column_address;
  logic [ROW_ADDR_WIDTH-1:0] row_address;
  logic [ROW_ADDR_WIDTH-1:0] row_address_active;
  logic [PLANES-1:0]         brightness_mask;
  logic                      clk_pixel_load;
  logic                      clk_pixel;
  logic                      row_latch;
  logic                      output_enable;
  logic                      frame_start;

  modport master (
    input  brightness,
    output column_address, row_address, row_address_active, brightness_mask,
    output clk_pixel_load, clk_pixel, row_latch, output_enable, frame_start
  );

  modport slave (
    output brightness,
    input  column_address, row_address, row_address_active, brightness_mask,
    input  clk_pixel_load, clk_pixel, row_latch, output_enable, frame_start
  );
endinterface

// File: rtl/matrix_scan_bcm.sv
// HUB75 matrix scanner with binary-coded-modulation OE and global brightness.
// Optional anti-ghost blanking around row changes: define MATRIX_SCAN_GHOST_BLANK_EN.
module matrix_scan_bcm #(
  parameter int COLUMNS        = 64,
  parameter int COL_ADDR_WIDTH = 6,
  parameter int ROW_ADDR_WIDTH = 4,
  parameter int PLANES         = 6,
  parameter int BASE_ON        = 64,
  parameter int ON_WIDTH       = 16,
  parameter int BLANK_CYCLES   = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  matrix_scan_bcm_if.master bus
);
  localparam int PW     = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int PROD_W = ON_WIDTH + 9;

  if (COLUMNS < 2 || (1 << COL_ADDR_WIDTH) < COLUMNS || BLANK_CYCLES < 0 ||
      (BASE_ON << (PLANES - 1)) >= (1 << ON_WIDTH)) begin : g_bad_params
    $error("matrix_scan_bcm: inconsistent parameters");
  end

  typedef enum logic {SHIFT, READY} state_t;

  state_t                    state, state_next;
  logic                      started;
  logic [1:0]                phase, phase_next;
  logic [COL_ADDR_WIDTH-1:0] col, col_next;
  logic [PW-1:0]             plane, plane_next;
  logic [ROW_ADDR_WIDTH-1:0] row, row_next, row_active, row_active_next;
  logic [ON_WIDTH-1:0]       on_cnt, on_cnt_next, on_time;
  logic [PROD_W-1:0]         on_prod;
  logic                      row_change, latch_ok, latch, on_run;

  assign row_change = (plane == PW'(PLANES - 1));
  // Brightness is only looked at here, so it can only matter at a latch.
  assign on_prod = (PROD_W'(BASE_ON) << plane) * (PROD_W'(bus.brightness) + PROD_W'(1));
  assign on_time = ON_WIDTH'(on_prod >> 8);

`ifdef MATRIX_SCAN_GHOST_BLANK_EN
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  logic [BW-1:0] pre_cnt, pre_cnt_next, hold_cnt, hold_cnt_next;

  // OE and the on-time countdown are frozen while the post-latch blank runs.
  assign on_run = (hold_cnt == '0);

  always_comb begin
    pre_cnt_next  = pre_cnt;
    hold_cnt_next = (hold_cnt != '0) ? hold_cnt - BW'(1) : hold_cnt;
    latch_ok      = (state == READY) && (on_cnt == '0);
    if (latch_ok && row_change) begin
      if (pre_cnt == BW'(BLANK_CYCLES)) begin
        pre_cnt_next  = '0;
        hold_cnt_next = BW'(BLANK_CYCLES);
      end else begin
        pre_cnt_next = pre_cnt + BW'(1);
        latch_ok     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pre_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      pre_cnt  <= pre_cnt_next;
      hold_cnt <= hold_cnt_next;
    end
  end
`else
  assign on_run   = 1'b1;
  assign latch_ok = (state == READY) && (on_cnt == '0);
`endif

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next      = state;
    phase_next      = phase;
    col_next        = col;
    plane_next      = plane;
    row_next        = row;
    row_active_next = row_active;
    on_cnt_next     = (on_run && on_cnt != '0) ? on_cnt - ON_WIDTH'(1) : on_cnt;
    latch           = 1'b0;
    if (started) begin
      unique case (state)
        SHIFT: begin
          phase_next = phase + 2'd1;
          if (phase == 2'd3) begin
            if (col == COL_ADDR_WIDTH'(COLUMNS - 1)) begin
              col_next   = '0;
              state_next = READY;
            end else begin
              col_next = col + COL_ADDR_WIDTH'(1);
            end
          end
        end
        READY: begin
          if (latch_ok) begin
            latch           = 1'b1;
            state_next      = SHIFT;
            on_cnt_next     = on_time;
            row_active_next = row;
            if (row_change) begin
              plane_next = '0;
              row_next   = row + ROW_ADDR_WIDTH'(1);
            end else begin
              plane_next = plane + PW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use <= so every process sees the pre-edge values.
  // started holds the engine at k0 of column 0 for the first post-reset cycle.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      started    <= 1'b0;
      state      <= SHIFT;
      phase      <= 2'd0;
      col        <= '0;
      plane      <= '0;
      row        <= '0;
      row_active <= '0;
      on_cnt     <= '0;
    end else begin
      started    <= 1'b1;
      state      <= state_next;
      phase      <= phase_next;
      col        <= col_next;
      plane      <= plane_next;
      row        <= row_next;
      row_active <= row_active_next;
      on_cnt     <= on_cnt_next;
    end
  end

  assign bus.column_address     = col;
  assign bus.row_address        = row;
  assign bus.row_address_active = row_active;
  assign bus.brightness_mask    = PLANES'(1) << plane;
  assign bus.clk_pixel_load     = started && (state == SHIFT) && (phase == 2'd0);
  assign bus.clk_pixel          = started && (state == SHIFT) && (phase == 2'd2);
  assign bus.row_latch          = latch;
  assign bus.output_enable      = on_run && (on_cnt != '0);
  assign bus.frame_start        = latch && (row == '0) && (plane == '0);
endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Directed bench for matrix_scan_bcm: 4 columns, 2 rows, 2 planes, BASE_ON 8 (and 32).
// Expectations follow MATRIX_SCAN_GHOST_BLANK_EN when it is defined (BLANK_CYCLES=3).
module tb_matrix_scan_bcm;
`ifdef MATRIX_SCAN_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif
  localparam logic [10:0] RST_OUTS = {2'b00, 1'b0, 1'b0, 2'b01, 5'b00000};

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk_in = ~clk_in;

  matrix_scan_bcm_if #(.COL_ADDR_WIDTH(2), .ROW_ADDR_WIDTH(1), .PLANES(2)) bus ();
  matrix_scan_bcm_if #(.COL_ADDR_WIDTH(2), .ROW_ADDR_WIDTH(1), .PLANES(2)) bus_long ();

  matrix_scan_bcm #(
    .COLUMNS(4), .COL_ADDR_WIDTH(2), .ROW_ADDR_WIDTH(1), .PLANES(2),
    .BASE_ON(8), .ON_WIDTH(8), .BLANK_CYCLES(3)
  ) dut (.clk_in(clk_in), .reset(reset), .bus(bus));

  matrix_scan_bcm #(
    .COLUMNS(4), .COL_ADDR_WIDTH(2), .ROW_ADDR_WIDTH(1), .PLANES(2),
    .BASE_ON(32), .ON_WIDTH(8), .BLANK_CYCLES(3)
  ) dut_long (.clk_in(clk_in), .reset(reset), .bus(bus_long));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [4:0] main_flags();
    return {bus.clk_pixel_load, bus.clk_pixel, bus.row_latch, bus.frame_start, bus.output_enable};
  endfunction

  function automatic logic [10:0] main_outs();
    return {bus.column_address, bus.row_address, bus.row_address_active,
            bus.brightness_mask, main_flags()};
  endfunction

  // First slot after reset release: loads at 0,4,8,12, shift clock at 2,6,10,14, latch at 16.
  task automatic check_main_cycle(input string pfx, input int n);
    logic [4:0] exp;
    exp = {n < 16 && n % 4 == 0, n < 16 && n % 4 == 2, n == 16, n == 16, 1'b0};
    check($sformatf("%s_flags_c%0d", pfx, n), main_flags(), exp);
    if (n < 16 && n % 4 == 0) check($sformatf("%s_col_c%0d", pfx, n), bus.column_address, n / 4);
    if (n == 16) check($sformatf("%s_slot0", pfx), {bus.row_address, bus.brightness_mask}, 3'b001);
  endtask

  // Steps from one latch to the next; counts cycles, OE-high cycles and the first OE-high offset.
  task automatic next_latch(input logic [7:0] bri, output int gap, output int oe_cnt, output int rise);
    gap = 0; oe_cnt = 0; rise = 0;
    do begin
      @(posedge clk_in);
      #1;
      if (gap == 0) bus.brightness = bri;
      @(negedge clk_in);
      gap++;
      if (bus.output_enable) begin
        oe_cnt++;
        if (rise == 0) rise = gap;
      end
    end while (!bus.row_latch && gap < 100);
  endtask

  initial begin
    int gap, oe_cnt, rise, s, long_l2;
    bit in_shift;
    logic [7:0] bri;
    int oe_exp    [2:9] = '{8, 16, 8, 16, 4, 8, 0, 0};
    int gap_ghost [2:9] = '{20, 20, 20, 20, 20, 17, 20, 17};
    int rise_gh   [2:9] = '{1, 4, 1, 4, 1, 4, 0, 0};

    bus.brightness      = 8'd255;
    bus_long.brightness = 8'd255;
    long_l2 = GHOST ? 52 : 49;

    repeat (3) begin
      @(negedge clk_in);
      check("reset_state", main_outs(), RST_OUTS);
    end
    reset = 1'b1;

    // Both instances from the same release; the long one defers its second latch.
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_in);
      if (n <= 16) check_main_cycle("a", n);
      s        = (n >= 17) ? n - 17 : n;
      in_shift = (n < 16) || (n >= 17 && n <= 32);
      check($sformatf("long_c%0d", n),
            {bus_long.clk_pixel_load, bus_long.clk_pixel, bus_long.row_latch,
             bus_long.frame_start, bus_long.output_enable},
            {in_shift && s % 4 == 0, in_shift && s % 4 == 2, n == 16 || n == long_l2,
             n == 16, n >= 17 && n <= 48});
    end

    // Reset in the middle of an OE pulse must clear outputs without a clock edge.
    check("oe_before_reset", bus.output_enable, 1'b1);
    #2 reset = 1'b0;
    #1 check("async_reset", main_outs(), RST_OUTS);
    @(negedge clk_in);
    reset = 1'b1;
    for (int n = 0; n <= 16; n++) begin
      @(negedge clk_in);
      check_main_cycle("c", n);
    end

    // Latches 2..9: brightness 255, then 127, then 0, each applied right after a latch.
    for (int k = 2; k <= 9; k++) begin
      bri = (k <= 4) ? 8'd255 : (k <= 6) ? 8'd127 : 8'd0;
      next_latch(bri, gap, oe_cnt, rise);
      check($sformatf("gap_l%0d", k), gap, GHOST ? gap_ghost[k] : 17);
      check($sformatf("oe_len_l%0d", k), oe_cnt, oe_exp[k]);
      check($sformatf("oe_rise_l%0d", k), rise, GHOST ? rise_gh[k] : (oe_exp[k] > 0 ? 1 : 0));
      check($sformatf("mask_l%0d", k), bus.brightness_mask, (k % 2 == 1) ? 2'b01 : 2'b10);
      check($sformatf("frame_l%0d", k), bus.frame_start, k == 5 || k == 9);
      check($sformatf("active_l%0d", k), bus.row_address_active, ((k - 2) / 2) % 2);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
